// File: rtl/raymarch_scheduler_if.sv
// raymarch_scheduler_if: frame control, core array and framebuffer signals of the scheduler
interface raymarch_scheduler_if #(
  parameter int WIDTH = 1280,
  parameter int HEIGHT = 720,
  parameter int NUM_CORES = 4
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = $clog2(WIDTH * HEIGHT);
  logic frame_start_in;
  logic [NUM_CORES-1:0] core_start_out;
  logic [NUM_CORES-1:0][XW-1:0] core_x_out;
  logic [NUM_CORES-1:0][YW-1:0] core_y_out;
  logic [NUM_CORES-1:0] core_done_in;
  logic [NUM_CORES-1:0][23:0] core_color_in;
  logic fb_we_out;
  logic [AW-1:0] fb_addr_out;
  logic [23:0] fb_data_out;
  logic frame_busy_out;
  logic frame_done_out;
  modport slave (
    input  frame_start_in, core_done_in, core_color_in,
    output core_start_out, core_x_out, core_y_out, fb_we_out, fb_addr_out, fb_data_out,
           frame_busy_out, frame_done_out
  );
  modport master (
    output frame_start_in, core_done_in, core_color_in,
    input  core_start_out, core_x_out, core_y_out, fb_we_out, fb_addr_out, fb_data_out,
           frame_busy_out, frame_done_out
  );
endinterface

// File: rtl/raymarch_scheduler.sv
// raymarch_scheduler: shares NUM_CORES raymarcher cores across a frame and serialises results to the framebuffer
module raymarch_scheduler #(
  parameter int WIDTH = 1280,
  parameter int HEIGHT = 720,
  parameter int NUM_CORES = 4
) (
  input logic clk_pixel_in,
  input logic rst_in,
  raymarch_scheduler_if.slave bus_io
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = $clog2(WIDTH * HEIGHT);
  localparam int PW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);
  localparam logic [PW-1:0] PMAX = PW'(NUM_CORES - 1);
  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_e;
  typedef enum logic [1:0] {FREE, BUSY, PEND} core_e;
  state_e state_q;
  core_e st_q [NUM_CORES];
  logic [NUM_CORES-1:0][XW-1:0] x_q;
  logic [NUM_CORES-1:0][YW-1:0] y_q;
  logic [AW-1:0] addr_q [NUM_CORES];
  logic [23:0] col_q [NUM_CORES];
  logic [XW-1:0] rx_q;
  logic [YW-1:0] ry_q;
  logic [AW-1:0] ra_q;
  logic [PW-1:0] dptr_q, wptr_q, d_idx, w_idx;
  logic d_ok, w_ok, active, dispatch, last;
  logic [NUM_CORES-1:0] start_q;
  logic we_q;
  logic [AW-1:0] fa_q;
  logic [23:0] fd_q;
  // Round-robin search; scanning downwards lets the nearest match to the pointer win.
  always_comb begin
    int dj, wj;
    dj = 0;
    wj = 0;
    d_ok = 1'b0;
    w_ok = 1'b0;
    d_idx = '0;
    w_idx = '0;
    active = 1'b0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      dj = int'(dptr_q) + k;
      dj = dj >= NUM_CORES ? dj - NUM_CORES : dj;
      wj = int'(wptr_q) + k;
      wj = wj >= NUM_CORES ? wj - NUM_CORES : wj;
      if (st_q[dj] == FREE) begin
        d_ok = 1'b1;
        d_idx = PW'(dj);
      end
      if (st_q[wj] == PEND) begin
        w_ok = 1'b1;
        w_idx = PW'(wj);
      end
    end
    for (int i = 0; i < NUM_CORES; i++) active = active | (st_q[i] != FREE);
    dispatch = (state_q == DISPATCH) && d_ok;
    last = (rx_q == XMAX) && (ry_q == YMAX);
  end
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_CORES; i++) begin
        st_q[i] <= FREE;
        addr_q[i] <= '0;
        col_q[i] <= '0;
      end
      x_q <= '0;
      y_q <= '0;
      rx_q <= '0;
      ry_q <= '0;
      ra_q <= '0;
      dptr_q <= '0;
      wptr_q <= '0;
      start_q <= '0;
      we_q <= 1'b0;
      fa_q <= '0;
      fd_q <= '0;
    end else begin
      start_q <= '0;
      we_q <= w_ok;
      state_q <= state_q == IDLE ? (bus_io.frame_start_in ? DISPATCH : IDLE) :
                 state_q == DISPATCH ? (dispatch && last ? DRAIN : DISPATCH) :
                 state_q == DRAIN ? (active ? DRAIN : DONE) : IDLE;
      for (int i = 0; i < NUM_CORES; i++)
        if (bus_io.core_done_in[i] && st_q[i] == BUSY) begin
          st_q[i] <= PEND;
          col_q[i] <= bus_io.core_color_in[i];
        end
      if (w_ok) begin
        st_q[w_idx] <= FREE;
        fa_q <= addr_q[w_idx];
        fd_q <= col_q[w_idx];
        wptr_q <= w_idx == PMAX ? '0 : w_idx + 1'b1;
      end
      if (dispatch) begin
        st_q[d_idx] <= BUSY;
        start_q[d_idx] <= 1'b1;
        x_q[d_idx] <= rx_q;
        y_q[d_idx] <= ry_q;
        addr_q[d_idx] <= ra_q;
        dptr_q <= d_idx == PMAX ? '0 : d_idx + 1'b1;
        rx_q <= rx_q == XMAX ? '0 : rx_q + 1'b1;
        ry_q <= last ? '0 : (rx_q == XMAX ? ry_q + 1'b1 : ry_q);
        ra_q <= last ? '0 : ra_q + 1'b1;
      end
    end
  end
  assign bus_io.core_start_out = start_q;
  assign bus_io.core_x_out = x_q;
  assign bus_io.core_y_out = y_q;
  assign bus_io.fb_we_out = we_q;
  assign bus_io.fb_addr_out = fa_q;
  assign bus_io.fb_data_out = fd_q;
  assign bus_io.frame_busy_out = state_q != IDLE;
  assign bus_io.frame_done_out = state_q == DONE;
endmodule
